// File: rtl/chunked_adder_pkg.sv
// Shared types and elaboration helpers for the chunked wide adder.
package chunked_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned chunk_w);
    return idx * chunk_w;
  endfunction

  function automatic bit widths_ok(input int unsigned total_w, input int unsigned chunk_w);
    return (chunk_w != 32'd0) && (total_w != 32'd0) && ((total_w % chunk_w) == 32'd0);
  endfunction

endpackage

// File: rtl/chunked_adder_if.sv
// Operand/result handshake bundle for chunked_adder; Ovf exists only with CHUNKED_ADDER_OVF_EN.
interface chunked_adder_if #(
  parameter int unsigned TOTAL_W = 64
);
  logic               in_valid;
  logic               in_ready;
  logic [TOTAL_W-1:0] A;
  logic [TOTAL_W-1:0] B;
  logic               Cin;
  logic               out_valid;
  logic               out_ready;
  logic [TOTAL_W-1:0] Sum;
  logic               Cout;
  logic               busy;
`ifdef CHUNKED_ADDER_OVF_EN
  logic               Ovf;
`endif

  modport slave (
    input  in_valid, A, B, Cin, out_ready,
    output in_ready, out_valid, Sum, Cout, busy
`ifdef CHUNKED_ADDER_OVF_EN
    , output Ovf
`endif
  );

  modport master (
    output in_valid, A, B, Cin, out_ready,
    input  in_ready, out_valid, Sum, Cout, busy
`ifdef CHUNKED_ADDER_OVF_EN
    , input Ovf
`endif
  );
endinterface

// File: rtl/rca.sv
// Plain W-bit ripple-carry adder; one instance is time-shared across all slices.
module rca #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);
  logic [W:0] c_s;

  // Bit-serial carry chain across the slice
  always_comb begin
    c_s    = '0;
    c_s[0] = cin_i;
    sum_o  = '0;
    for (int i = 0; i < int'(W); i++) begin
      sum_o[i]  = a_i[i] ^ b_i[i] ^ c_s[i];
      c_s[i+1]  = (a_i[i] & b_i[i]) | (c_s[i] & (a_i[i] ^ b_i[i]));
    end
    cout_o = c_s[W];
  end
endmodule

// File: rtl/chunked_adder.sv
// Multi-cycle TOTAL_W adder, one CHUNK_W slice per cycle LSB first.
// Optional signed-overflow output enabled by CHUNKED_ADDER_OVF_EN.
module chunked_adder
  import chunked_adder_pkg::*;
#(
  parameter int unsigned TOTAL_W = 64,
  parameter int unsigned CHUNK_W = 8
) (
  input logic           clk,
  input logic           rst,
  chunked_adder_if.slave bus
);
  localparam int unsigned NCHUNK = TOTAL_W / CHUNK_W;
  localparam int unsigned IDX_W  = (NCHUNK > 32'd1) ? $clog2(NCHUNK) : 32'd1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 32'd1);

  if (!widths_ok(TOTAL_W, CHUNK_W)) begin : g_width_err
    $error("chunked_adder: TOTAL_W must be a nonzero multiple of CHUNK_W");
  end

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [TOTAL_W-1:0] a_q, a_d;
  logic [TOTAL_W-1:0] b_q, b_d;
  logic [TOTAL_W-1:0] sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic [CHUNK_W-1:0] a_slice_s, b_slice_s, rca_sum_s;
  logic               rca_cout_s;
`ifdef CHUNKED_ADDER_OVF_EN
  logic               ovf_q, ovf_d;
  logic               msb_cin_s;
`endif

  assign a_slice_s = a_q[slice_lo(32'(idx_q), CHUNK_W) +: CHUNK_W];
  assign b_slice_s = b_q[slice_lo(32'(idx_q), CHUNK_W) +: CHUNK_W];

  rca #(.W(CHUNK_W)) u_rca (
    .a_i    (a_slice_s),
    .b_i    (b_slice_s),
    .cin_i  (carry_q),
    .sum_o  (rca_sum_s),
    .cout_o (rca_cout_s)
  );

`ifdef CHUNKED_ADDER_OVF_EN
  // Carry into the slice MSB is recovered from its sum bit
  assign msb_cin_s = a_slice_s[CHUNK_W-1] ^ b_slice_s[CHUNK_W-1] ^ rca_sum_s[CHUNK_W-1];
`endif

  // Next-state, slice datapath and handshake outputs
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
`ifdef CHUNKED_ADDER_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          a_d     = bus.A;
          b_d     = bus.B;
          carry_d = bus.Cin;
          idx_d   = '0;
          sum_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sum_d[slice_lo(32'(idx_q), CHUNK_W) +: CHUNK_W] = rca_sum_s;
        carry_d = rca_cout_s;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          cout_d  = rca_cout_s;
`ifdef CHUNKED_ADDER_OVF_EN
          ovf_d   = msb_cin_s ^ rca_cout_s;
`endif
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = RUN;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef CHUNKED_ADDER_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef CHUNKED_ADDER_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.Sum       = sum_q;
  assign bus.Cout      = cout_q;
`ifdef CHUNKED_ADDER_OVF_EN
  assign bus.Ovf       = ovf_q;
`endif
endmodule

// File: tb/tb_chunked_adder.sv
// Directed bench for chunked_adder; define CHUNKED_ADDER_OVF_EN to also cover Ovf.
module tb_chunked_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec  = 0;
  int   n_miss = 0;
  logic prev_cout = 1'b0;

  always #5 clk = ~clk;

  chunked_adder_if #(.TOTAL_W(64)) bus ();

  chunked_adder #(.TOTAL_W(64), .CHUNK_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one operand set at a negedge and return just after the accept edge.
  task automatic start_op(input logic [63:0] a, input logic [63:0] b, input logic cin);
    int w = 0;
    while (!bus.in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("in_ready_wait", {63'd0, bus.in_ready}, 64'd1);
    bus.A        = a;
    bus.B        = b;
    bus.Cin      = cin;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.A        = ~a;
    bus.B        = ~b;
    bus.Cin      = ~cin;
    check("accept_sum_cleared", bus.Sum, 64'd0);
    check("accept_cout_kept", {63'd0, bus.Cout}, {63'd0, prev_cout});
    check("accept_busy", {63'd0, bus.busy}, 64'd1);
    check("accept_in_ready", {63'd0, bus.in_ready}, 64'd0);
  endtask

  task automatic finish_op(input string tag, input logic [63:0] exp_sum,
                           input logic exp_cout, input logic exp_ovf);
    int cnt = 0;
    while (!bus.out_valid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check({tag, "_latency"}, 64'(cnt), 64'd8);
    check({tag, "_sum"}, bus.Sum, exp_sum);
    check({tag, "_cout"}, {63'd0, bus.Cout}, {63'd0, exp_cout});
`ifdef CHUNKED_ADDER_OVF_EN
    check({tag, "_ovf"}, {63'd0, bus.Ovf}, {63'd0, exp_ovf});
`else
    if (exp_ovf !== 1'b0 && exp_ovf !== 1'b1) $display("note: %s ovf unknown", tag);
`endif
    check({tag, "_no_overlap"}, {63'd0, bus.in_ready}, 64'd0);
    prev_cout = exp_cout;
    if (bus.out_ready) begin
      @(negedge clk);
      check({tag, "_valid_drop"}, {63'd0, bus.out_valid}, 64'd0);
      check({tag, "_ready_back"}, {63'd0, bus.in_ready}, 64'd1);
      check({tag, "_sum_hold"}, bus.Sum, exp_sum);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.A         = 64'd0;
    bus.B         = 64'd0;
    bus.Cin       = 1'b0;
    #2;
    check("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_sum", bus.Sum, 64'd0);
    check("rst_cout", {63'd0, bus.Cout}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    check("post_rst_busy", {63'd0, bus.busy}, 64'd0);

    start_op(64'h65, 64'h65, 1'b0);
    finish_op("basic", 64'hCA, 1'b0, 1'b0);

    start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
    finish_op("full_ripple", 64'd0, 1'b1, 1'b0);

    start_op(64'hFF, 64'h01, 1'b0);
    finish_op("slice_carry", 64'h100, 1'b0, 1'b0);

    start_op(64'h7F, 64'h01, 1'b1);
    finish_op("with_cin", 64'h81, 1'b0, 1'b0);

    // Backpressure: result must stay stable and new operands be ignored
    bus.out_ready = 1'b0;
    start_op(64'hA5A5, 64'h5A5A, 1'b0);
    finish_op("stall", 64'hFFFF, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.A        = 64'h1;
      bus.B        = 64'h1;
      @(negedge clk);
      check("stall_valid", {63'd0, bus.out_valid}, 64'd1);
      check("stall_sum", bus.Sum, 64'hFFFF);
      check("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("release_valid", {63'd0, bus.out_valid}, 64'd0);
    check("release_in_ready", {63'd0, bus.in_ready}, 64'd1);
    check("release_sum_hold", bus.Sum, 64'hFFFF);

    // Reset while RUN at idx 3
    start_op(64'h1234, 64'h1, 1'b0);
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_sum", bus.Sum, 64'd0);
    check("midrst_cout", {63'd0, bus.Cout}, 64'd0);
    check("midrst_busy", {63'd0, bus.busy}, 64'd0);
    check("midrst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    check("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
`ifdef CHUNKED_ADDER_OVF_EN
    check("midrst_ovf", {63'd0, bus.Ovf}, 64'd0);
`endif
    prev_cout = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_release_ready", {63'd0, bus.in_ready}, 64'd1);
    check("midrst_no_valid", {63'd0, bus.out_valid}, 64'd0);
    start_op(64'h10, 64'h20, 1'b0);
    finish_op("after_rst", 64'h30, 1'b0, 1'b0);

`ifdef CHUNKED_ADDER_OVF_EN
    start_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    finish_op("ovf_pos", 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    start_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
    finish_op("ovf_neg", 64'd0, 1'b1, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/chunked_adder.md
Name: chunked_adder

Overview:
- Multi-cycle wide adder that feeds the existing `rca` ripple-carry adder one slice per cycle.
- Adds TOTAL_W-bit operands as NCHUNK = TOTAL_W/CHUNK_W sequential CHUNK_W-bit slices, LSB slice first.
- Carry is registered between slices, so the critical path is one CHUNK_W-bit ripple.
- Sits between an operand producer (valid/ready) and a result consumer (valid/ready) in the datapath.

Parameters:
- TOTAL_W, 64, operand and result width.
- CHUNK_W, 8, width of the single rca instance; TOTAL_W % CHUNK_W must be 0; elaboration error otherwise.
- NCHUNK, TOTAL_W/CHUNK_W, derived localparam; number of compute cycles.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand/Cin presented.
- in_ready  out  1  block accepts operands.
- A  in  TOTAL_W  operand A.
- B  in  TOTAL_W  operand B.
- Cin  in  1  carry-in.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- Sum  out  TOTAL_W  registered sum.
- Cout  out  1  registered carry-out of the MSB slice.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (async assert, sync release):
  - State is IDLE; slice index 0; carry register 0.
  - A/B capture registers 0; Sum 0; Cout 0; out_valid 0; busy 0.
  - in_ready is 0 while rst is high and 1 in the first cycle after release.
- States:
  - IDLE: in_ready=1, out_valid=0, busy=0.
    - On the edge where in_valid & in_ready: capture A, B; carry_reg<=Cin; idx<=0; Sum<=0; go to RUN.
  - RUN: in_ready=0, busy=1.
    - Each cycle, rca inputs are A_reg[idx slice], B_reg[idx slice], carry_reg.
    - At the edge: Sum[idx slice]<=rca Sum; carry_reg<=rca Cout; idx<=idx+1.
    - When idx==NCHUNK-1 at the edge: also Cout<=rca Cout; go to DONE.
  - DONE: out_valid=1, in_ready=0, busy=1; Sum/Cout held stable.
    - On out_valid & out_ready: go to IDLE; out_valid falls next cycle.
- Latency: the accept edge is edge 0; out_valid is high after edge NCHUNK (8 cycles for defaults).
- Throughput: at most one operation per NCHUNK+2 cycles. There is no overlap: in_ready is never 1 while out_valid is 1.
- Sum/Cout keep the last result through IDLE until the next accept.
- Only Sum is cleared at accept; Cout is retained until the MSB slice of the next operation writes it.
- in_valid during RUN/DONE is ignored; A/B/Cin changes after accept have no effect.
- out_ready held low in DONE stalls indefinitely with the result stable.
- idx wraps only through the RUN→DONE transition; it never exceeds NCHUNK-1.
- Arithmetic: {Cout,Sum} == A + B + Cin, modulo 2^(TOTAL_W+1); unsigned.
- Reset mid-RUN or mid-DONE: immediate return to reset values; the partial result is discarded; no out_valid pulse.
- NCHUNK==1 (CHUNK_W==TOTAL_W): RUN lasts one cycle; out_valid after edge 1.

Optional Feature:
- Macro CHUNKED_ADDER_OVF_EN.
- When defined:
  - Adds output port Ovf (1 bit), the signed two's-complement overflow of A+B+Cin.
  - Ovf = carry into MSB XOR carry out of MSB, captured in the last RUN cycle from the top slice.
  - Ovf follows the same reset, hold and update rules as Cout.
- When undefined: port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package chunked_adder_pkg holds:
  - state_t enum {IDLE, RUN, DONE}, 2 bits.
  - Function slice_lo(idx) returning idx*CHUNK_W.
  - A width-check helper used at elaboration.
- One sub-module: the existing rca #(CHUNK_W), instantiated once. The combinational ripple stays inside rca.
- FSM, index counter and carry/result registers live in chunked_adder.

Test Plan:
- A=0x65, B=0x65, Cin=0, out_ready=1 → out_valid exactly 8 cycles after accept; Sum=0x...00CA; Cout=0.
- A=0xFFFF_FFFF_FFFF_FFFF, B=0, Cin=1 → Sum=0, Cout=1; the carry ripples through all 8 slices.
- A=0xFF, B=0x01, Cin=0 → Sum=0x100 (carry across the slice 0→1 boundary); then A=0x7F, B=0x01, Cin=1 → Sum=0x81.
- Backpressure, A=0xA5A5, B=0x5A5A: out_ready=0 for 5 cycles in DONE → Sum=0xFFFF and out_valid held stable; in_ready=0 and a new in_valid is ignored; release → IDLE, in_ready=1 next cycle.
- Reset mid-op: assert rst at RUN idx=3 → outputs go to reset values asynchronously; no out_valid; the next operation (0x10+0x20) gives 0x30.
- With CHUNKED_ADDER_OVF_EN: A=0x7FFF_FFFF_FFFF_FFFF, B=1 → Ovf=1, Cout=0; A=B=0x8000_0000_0000_0000 → Ovf=1, Cout=1, Sum=0.
